coffee_vend_ctrl: RTL and testbench

COFFEE_VEND_CTRL -- requirements
Module: coffee_vend_ctrl

---
 rtl/coffee_pkg.sv | 34 +++
 rtl/credit_compare.sv | 15 +
 rtl/coffee_vend_ctrl.sv | 145 ++++++++++++++
 tb/tb_coffee_vend_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types for the coffee vending controller.
// FSM states, coin codes and the coin-to-credit mapping.
package coffee_pkg;

    localparam int CREDIT_W = 4;
    localparam logic [1:0] SEL_INVALID = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_CHANGE
    } state_e;

    typedef enum logic [1:0] {
        COIN_1,
        COIN_2,
        COIN_5,
        COIN_10
    } coin_e;

    function automatic logic [CREDIT_W-1:0] coin_value(input coin_e c);
        logic [CREDIT_W-1:0] v;
        unique case (c)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_5:  v = 4'd5;
            COIN_10: v = 4'd10;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/credit_compare.sv
// Unsigned credit-versus-price check.
// Overpayment counts as paid; diff is the change owed.
module credit_compare
    import coffee_pkg::*;
(
    input  logic [CREDIT_W-1:0] i_credit,
    input  logic [CREDIT_W-1:0] i_price,
    output logic                o_paid,
    output logic [CREDIT_W-1:0] o_diff
);

    assign o_paid = (i_credit >= i_price);
    assign o_diff = o_paid ? (i_credit - i_price) : '0;

endmodule

// File: rtl/coffee_vend_ctrl.sv
// Coffee vending controller: selection, coin collection,
// dispense handshake and change return. All outputs registered.
module coffee_vend_ctrl
    import coffee_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] PRICE0 = 4'd3,
    parameter logic [CREDIT_W-1:0] PRICE1 = 4'd5,
    parameter logic [CREDIT_W-1:0] PRICE2 = 4'd6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                dispense_done,
    output logic                dispense_req,
    output logic [1:0]          drink,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                busy
);

    state_e              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic [1:0]          r_drink;
    logic                r_disp;
    logic                r_rej;
    logic                r_chg_v;
    logic [CREDIT_W-1:0] r_chg_amt;
    logic                r_busy;

    state_e              w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_price_nxt;
    logic [1:0]          w_drink_nxt;
    logic                w_rej_nxt;
    logic                w_chg_v_nxt;
    logic [CREDIT_W-1:0] w_chg_amt_nxt;

    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_paid;
    logic [CREDIT_W-1:0] w_diff;

    credit_compare u_cmp (
        .i_credit (r_credit),
        .i_price  (r_price),
        .o_paid   (w_paid),
        .o_diff   (w_diff)
    );

    // Extra MSB catches coins that would overflow the 4-bit credit.
    assign w_sum = {1'b0, r_credit}
                 + {1'b0, coin_value(coin_e'(coin_val))};

    assign w_sel_price = (sel == 2'd0) ? PRICE0 :
                         (sel == 2'd1) ? PRICE1 : PRICE2;

    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_price_nxt   = r_price;
        w_drink_nxt   = r_drink;
        w_rej_nxt     = coin_valid;
        w_chg_v_nxt   = 1'b0;
        w_chg_amt_nxt = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (sel_valid && sel != SEL_INVALID) begin
                    w_state_nxt = ST_COLLECT;
                    w_price_nxt = w_sel_price;
                    w_drink_nxt = sel;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    w_chg_v_nxt   = (r_credit != '0);
                    w_chg_amt_nxt = r_credit;
                    w_credit_nxt  = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    if (coin_valid && !w_sum[CREDIT_W]) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_rej_nxt    = 1'b0;
                    end
                    if (w_paid) begin
                        w_state_nxt = ST_DISPENSE;
                    end
                end
            end
            ST_DISPENSE: begin
                if (dispense_done) begin
                    w_state_nxt   = ST_CHANGE;
                    w_chg_v_nxt   = (w_diff != '0);
                    w_chg_amt_nxt = w_diff;
                end
            end
            ST_CHANGE: begin
                w_credit_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_credit  <= '0;
            r_price   <= '0;
            r_drink   <= '0;
            r_disp    <= 1'b0;
            r_rej     <= 1'b0;
            r_chg_v   <= 1'b0;
            r_chg_amt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_credit  <= w_credit_nxt;
            r_price   <= w_price_nxt;
            r_drink   <= w_drink_nxt;
            r_disp    <= (w_state_nxt == ST_DISPENSE);
            r_rej     <= w_rej_nxt;
            r_chg_v   <= w_chg_v_nxt;
            r_chg_amt <= w_chg_amt_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign dispense_req = r_disp;
    assign drink        = r_drink;
    assign credit       = r_credit;
    assign coin_reject  = r_rej;
    assign change_valid = r_chg_v;
    assign change_amt   = r_chg_amt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Directed bench for coffee_vend_ctrl: default prices on d_*,
// PRICE2=15 instance on h_*, both sharing one stimulus stream.
module tb_coffee_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = 2'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic       dispense_done = 1'b0;

    logic       d_req, d_rej, d_cv, d_busy;
    logic [1:0] d_drink;
    logic [3:0] d_credit, d_amt;
    logic       h_req, h_rej, h_cv, h_busy;
    logic [1:0] h_drink;
    logic [3:0] h_credit, h_amt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    coffee_vend_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel(sel),
        .cancel(cancel), .dispense_done(dispense_done),
        .dispense_req(d_req), .drink(d_drink),
        .credit(d_credit), .coin_reject(d_rej),
        .change_valid(d_cv), .change_amt(d_amt),
        .busy(d_busy)
    );

    coffee_vend_ctrl #(.PRICE2(4'd15)) u_dut15 (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel(sel),
        .cancel(cancel), .dispense_done(dispense_done),
        .dispense_req(h_req), .drink(h_drink),
        .credit(h_credit), .coin_reject(h_rej),
        .change_valid(h_cv), .change_amt(h_amt),
        .busy(h_busy)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin_val   = c;
    endtask

    initial begin
        #2000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #10;
        check("rst_req", d_req, 0);
        check("rst_credit", d_credit, 0);
        check("rst_busy", d_busy, 0);
        check("rst_cv", d_cv, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // drink 0, coins 1+2, exact payment
        sel_valid = 1; sel = 2'd0; tick;
        sel_valid = 0;
        check("t1_busy", d_busy, 1);
        coin(2'b00); tick;
        check("t1_cr1", d_credit, 1);
        coin(2'b01); tick;
        coin_valid = 0;
        check("t1_cr3", d_credit, 3);
        check("t1_req_early", d_req, 0);
        tick;
        check("t1_req", d_req, 1);
        check("t1_drink", d_drink, 0);
        tick;
        check("t1_req_hold", d_req, 1);
        dispense_done = 1; tick;
        dispense_done = 0;
        check("t1_req_drop", d_req, 0);
        check("t1_no_chg", d_cv, 0);
        check("t1_amt0", d_amt, 0);
        tick;
        check("t1_idle", d_busy, 0);
        check("t1_cr0", d_credit, 0);

        // drink 2, coin 10, change 4
        sel_valid = 1; sel = 2'd2; tick;
        sel_valid = 0;
        coin(2'b11); tick;
        coin_valid = 0;
        check("t2_cr10", d_credit, 10);
        tick;
        check("t2_req", d_req, 1);
        check("t2_drink", d_drink, 2);
        dispense_done = 1; tick;
        dispense_done = 0;
        check("t2_cv", d_cv, 1);
        check("t2_amt", d_amt, 4);
        tick;
        check("t2_cv_end", d_cv, 0);
        check("t2_amt_end", d_amt, 0);
        check("t2_cr0", d_credit, 0);
        check("t2_idle", d_busy, 0);

        // drink 1, coins 2+2, cancel with coin 1
        sel_valid = 1; sel = 2'd1; tick;
        sel_valid = 0;
        coin(2'b01); tick;
        coin(2'b01); tick;
        check("t3_cr4", d_credit, 4);
        coin(2'b00); cancel = 1; tick;
        coin_valid = 0; cancel = 0;
        check("t3_cv", d_cv, 1);
        check("t3_amt", d_amt, 4);
        check("t3_rej", d_rej, 1);
        check("t3_cr0", d_credit, 0);
        check("t3_idle", d_busy, 0);
        tick;
        check("t3_cv_end", d_cv, 0);
        check("t3_rej_end", d_rej, 0);

        // PRICE2=15: coins 10+10, second rejected
        sel_valid = 1; sel = 2'd2; tick;
        sel_valid = 0;
        coin(2'b11); tick;
        check("t4_cr10", h_credit, 10);
        coin(2'b11); tick;
        coin_valid = 0;
        check("t4_rej", h_rej, 1);
        check("t4_cr_kept", h_credit, 10);
        check("t4_still_collect", h_req, 0);
        check("t4_d_req", d_req, 1);
        check("t4_d_rej", d_rej, 1);
        cancel = 1; tick;
        cancel = 0;
        check("t4_cancel_cv", h_cv, 1);
        check("t4_cancel_amt", h_amt, 10);
        check("t4_idle", h_busy, 0);
        check("t4_d_ign_cancel", d_req, 1);
        check("t4_d_no_cv", d_cv, 0);
        coin(2'b00); tick;
        coin_valid = 0;
        check("t4_idle_rej", h_rej, 1);
        check("t4_d_disp_rej", d_rej, 1);
        check("t4_d_cr_kept", d_credit, 10);
        dispense_done = 1; tick;
        dispense_done = 0;
        check("t4_done_ign", h_busy, 0);
        check("t4_d_amt", d_amt, 4);
        tick;
        check("t4_d_idle", d_busy, 0);

        // reset during dispense
        sel_valid = 1; sel = 2'd0; tick;
        sel_valid = 0;
        coin(2'b01); tick;
        coin(2'b01); tick;
        coin_valid = 0;
        tick;
        check("t5_req", d_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_req_async", d_req, 0);
        check("t5_cr_async", d_credit, 0);
        check("t5_cv_async", d_cv, 0);
        check("t5_busy_async", d_busy, 0);
        tick;
        rst_n = 1'b1;
        sel_valid = 1; sel = 2'd3; tick;
        check("t5_sel3", d_busy, 0);
        check("t5_no_chg", d_cv, 0);
        sel = 2'd1; tick;
        sel_valid = 0;
        check("t5_resume", d_busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
